// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the FLAC frame sequencer.
//   FLAC_SYNC_14  - 14-bit frame sync pattern 0b11111111111110
//   SYNC_SPLIT_HI - upper six bits of the word that follows a split sync
//   seq_state_e   - sequencer FSM states SEQ_IDLE..SEQ_FINISH
//   sat_inc16     - 16-bit increment that sticks at all-ones
package frame_sequencer_pkg;

  localparam logic [13:0] FLAC_SYNC_14  = 14'b11111111111110;
  localparam logic [5:0]  SYNC_SPLIT_HI = 6'b111110;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_SCAN,
    SEQ_PRIME,
    SEQ_DECODE,
    SEQ_FINISH
  } seq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/frame_sequencer_sync_detector.sv
// Frame sync detector used while scanning word RAM.
// Compares each valid RAM word against the sync pattern, both word-aligned
// (sync in the high byte) and split across the previous low byte and the
// current high byte.
//   clk, rst_n  - clock, asynchronous active-low reset
//   data_valid  - data carries a real RAM word this cycle
//   data        - RAM word being compared
//   hit         - sync found in this word
//   upper       - 1: sync starts in the high byte of this word
//   offset      - 1: sync starts in the previous word (start address - 1)
module sync_detector
  import frame_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [15:0] data,
  output logic        hit,
  output logic        upper,
  output logic        offset
);

  logic [15:0] prev_q, prev_d;
  logic        aligned_hit;
  logic        split_hit;

  // The previous word is cleared whenever no valid word is present, so the
  // first compare of a fresh scan can never see a stale low byte.
  // Aligned and split hits are mutually exclusive: a split needs bits 15:10
  // to be 111110, an aligned hit needs bits 15:8 to be all ones.
  always_comb begin
    prev_d      = data_valid ? data : 16'h0000;
    aligned_hit = data_valid && (data[15:2] == FLAC_SYNC_14);
    split_hit   = data_valid && (prev_q[7:0] == 8'hFF) && (data[15:10] == SYNC_SPLIT_HI);
    hit         = aligned_hit || split_hit;
    upper       = aligned_hit;
    offset      = split_hit;
  end

  // Previous-word register for the split compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// FLAC frame sequencer.
// Scans word RAM (16-bit words, big-endian bytes) for frame syncs, primes and
// runs the frame decoder on each one, and rescans after good, bad or stalled
// frames. Owns the single RAM read port.
//   iClock, iReset_n        - clock, asynchronous active-low reset
//   iStart                  - start pulse, honoured only when idle
//   iStreamBase/iStreamEnd  - first / last (inclusive) stream word address
//   oDecReset/oDecEnable    - decoder reset and enable
//   oDecStartAddr/UpperBits - frame start word and byte lane (1 = high byte)
//   iDecFrameDone/BadFrame  - decoder completion / failure pulses
//   iDecSampleValid         - decoder produced a sample
//   iDecReadAddr            - decoder RAM address, forwarded while decoding
//   oRamReadAddr, iRamData  - RAM read port (1-cycle registered read)
//   oBusy, oDone            - not idle / one-cycle completion pulse
//   oFrameCount, oBadCount  - saturating good / bad frame counters
//   oSampleCount            - wrapping sample counter
//   oSyncLost               - sticky sync-search failure flag
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int WATCHDOG = 65535,
  parameter int MAX_SCAN = 4096
) (
  input  logic              iClock,
  input  logic              iReset_n,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iStreamBase,
  input  logic [ADDR_W-1:0] iStreamEnd,
  output logic              oDecReset,
  output logic              oDecEnable,
  output logic [ADDR_W-1:0] oDecStartAddr,
  output logic              oDecUpperBits,
  input  logic              iDecFrameDone,
  input  logic              iDecBadFrame,
  input  logic              iDecSampleValid,
  input  logic [ADDR_W-1:0] iDecReadAddr,
  output logic [ADDR_W-1:0] oRamReadAddr,
  input  logic [15:0]       iRamData,
  output logic              oBusy,
  output logic              oDone,
  output logic [15:0]       oFrameCount,
  output logic [15:0]       oBadCount,
  output logic [31:0]       oSampleCount,
  output logic              oSyncLost
);

  localparam int WD_W   = $clog2(WATCHDOG + 1);
  localparam int SCAN_W = $clog2(MAX_SCAN + 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WATCHDOG - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(MAX_SCAN - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              fill_q, fill_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic              prime_cnt_q, prime_cnt_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              upper_q, upper_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       bad_cnt_q, bad_cnt_d;
  logic [31:0]       sample_cnt_q, sample_cnt_d;
  logic              sync_lost_q, sync_lost_d;

  logic              det_valid;
  logic              det_hit;
  logic              det_upper;
  logic              det_offset;
  logic [ADDR_W-1:0] cmp_addr;
  logic [ADDR_W-1:0] next_ptr;
  logic              abort_frame;

  // RAM data arriving now belongs to the address issued last cycle.
  assign cmp_addr  = ptr_q - ADDR_W'(1);
  assign det_valid = (state_q == SEQ_SCAN) && !fill_q;

  sync_detector u_sync_detector (
    .clk        (iClock),
    .rst_n      (iReset_n),
    .data_valid (det_valid),
    .data       (iRamData),
    .hit        (det_hit),
    .upper      (det_upper),
    .offset     (det_offset)
  );

  // Next-state logic for the FSM, scan pointer, watchdog and counters.
  // The stream-end test uses the address just compared, before the pointer
  // advances, so a scan ending at the top of memory never wraps to zero.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    fill_d       = fill_q;
    scan_cnt_d   = scan_cnt_q;
    prime_cnt_d  = prime_cnt_q;
    start_addr_d = start_addr_q;
    upper_d      = upper_q;
    wd_d         = wd_q;
    frame_cnt_d  = frame_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    sample_cnt_d = sample_cnt_q;
    sync_lost_d  = sync_lost_q;
    next_ptr     = ptr_q;
    abort_frame  = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (iStart) begin
          frame_cnt_d  = '0;
          bad_cnt_d    = '0;
          sample_cnt_d = '0;
          sync_lost_d  = 1'b0;
          ptr_d        = iStreamBase;
          fill_d       = 1'b1;
          scan_cnt_d   = '0;
          state_d      = SEQ_SCAN;
        end
      end

      SEQ_SCAN: begin
        ptr_d  = ptr_q + ADDR_W'(1);
        fill_d = 1'b0;
        if (fill_q) begin
          if (ptr_q > iStreamEnd) begin
            sync_lost_d = 1'b1;
            state_d     = SEQ_FINISH;
          end
        end else if (det_hit) begin
          start_addr_d = cmp_addr - ADDR_W'(det_offset);
          upper_d      = det_upper;
          prime_cnt_d  = 1'b0;
          state_d      = SEQ_PRIME;
        end else if ((cmp_addr >= iStreamEnd) || (scan_cnt_q == SCAN_LAST)) begin
          sync_lost_d = 1'b1;
          state_d     = SEQ_FINISH;
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end

      SEQ_PRIME: begin
        prime_cnt_d = 1'b1;
        if (prime_cnt_q) begin
          wd_d    = '0;
          state_d = SEQ_DECODE;
        end
      end

      SEQ_DECODE: begin
        // The watchdog counts this cycle too, so the decoder gets exactly
        // WATCHDOG silent cycles before the frame is abandoned.
        if (iDecSampleValid) begin
          sample_cnt_d = sample_cnt_q + 32'd1;
          wd_d         = '0;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
        abort_frame = iDecBadFrame || (!iDecSampleValid && (wd_q == WD_LAST));
        if (abort_frame) begin
          bad_cnt_d = sat_inc16(bad_cnt_q);
          next_ptr  = start_addr_q + ADDR_W'(1);
        end else if (iDecFrameDone) begin
          frame_cnt_d = sat_inc16(frame_cnt_q);
          next_ptr    = iDecReadAddr - ADDR_W'(1);
        end
        if (abort_frame || iDecFrameDone) begin
          ptr_d      = next_ptr;
          fill_d     = 1'b1;
          scan_cnt_d = '0;
          state_d    = (next_ptr > iStreamEnd) ? SEQ_FINISH : SEQ_SCAN;
        end
      end

      SEQ_FINISH: begin
        state_d = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q      <= SEQ_IDLE;
      ptr_q        <= '0;
      fill_q       <= 1'b0;
      scan_cnt_q   <= '0;
      prime_cnt_q  <= 1'b0;
      start_addr_q <= '0;
      upper_q      <= 1'b0;
      wd_q         <= '0;
      frame_cnt_q  <= '0;
      bad_cnt_q    <= '0;
      sample_cnt_q <= '0;
      sync_lost_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      scan_cnt_q   <= scan_cnt_d;
      prime_cnt_q  <= prime_cnt_d;
      start_addr_q <= start_addr_d;
      upper_q      <= upper_d;
      wd_q         <= wd_d;
      frame_cnt_q  <= frame_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      sync_lost_q  <= sync_lost_d;
    end
  end

  // The decoder owns the RAM port only while it is enabled.
  always_comb begin
    oDecEnable    = (state_q == SEQ_DECODE);
    oDecReset     = (state_q != SEQ_DECODE);
    oBusy         = (state_q != SEQ_IDLE);
    oDone         = (state_q == SEQ_FINISH);
    oRamReadAddr  = (state_q == SEQ_DECODE) ? iDecReadAddr : ptr_q;
    oDecStartAddr = start_addr_q;
    oDecUpperBits = upper_q;
    oFrameCount   = frame_cnt_q;
    oBadCount     = bad_cnt_q;
    oSampleCount  = sample_cnt_q;
    oSyncLost     = sync_lost_q;
  end

endmodule
